num_entry_fifo: RTL and testbench
=================================

# num_entry_fifo

Input-side producer for the CPU's blocking number-input handshake. It captures the switch byte on each debounced key press into a small type-ahead FIFO. Whenever the CPU raises its wait request, it delivers the oldest entry as a one-cycle strobe. It sits between the debouncer and the control core's num_in/num_clk pins, so that values keyed in before the CPU asks are not lost.

## Interface
Parameters:
- DATA_W, 8, width of one entered value (switch field)
- DEPTH, 4, FIFO entries; must be a power of two, ≥2

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- key_in  in  1  debounced key level, active high
- sw_in  in  DATA_W  switch value, sampled on the key rising edge
- req  in  1  CPU wait request (the core's block level); high = CPU wants one value
- num_out  out  DATA_W  delivered value; valid while num_stb is high, held afterwards
- num_stb  out  1  one-cycle delivery strobe (drives num_clk)
- count  out  $clog2(DEPTH)+1  current occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky; set when a press arrives while full

## Operation
- Edge detect: key_q is a registered copy of key_in. A push is requested in any cycle where key_in=1 and key_q=0.
- Push: sw_in is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
  - If full and no pop occurs in the same cycle, the press is dropped and overflow is set.
  - overflow is cleared only by rst.
- FSM states: IDLE, WAIT_REL.
  - IDLE: if req=1 and !empty, pop mem[rd_ptr] into num_out, set num_stb=1 for the next cycle, and go to WAIT_REL.
  - WAIT_REL: num_stb=0. Stay until req is sampled 0, then return to IDLE.
  - WAIT_REL guarantees exactly one delivery per request, even if the core is slow to drop req.
- Simultaneous push and pop, including when full: both take effect and count is unchanged. No overflow is flagged.
- count increments on push-only, decrements on pop-only, and is unchanged otherwise.
- empty and full are derived from registered count, with no combinational path from inputs.
- Reset values:
  - num_out=0, num_stb=0, count=0, empty=1, full=0, overflow=0
  - pointers=0, state=IDLE
  - key_q=1, so a key held through reset release does not cause a spurious push.

## Timing
- All outputs are registered.
- Latency, non-bypass: first cycle with key_in high is cycle N → push at the end of N → pop decision in N+1 → num_stb high in N+2.
- If req rises while the FIFO is non-empty (req sampled high in cycle M), num_stb is high in M+1.
- Minimum spacing between strobes is 3 cycles: strobe, then ≥1 cycle with req sampled low, then IDLE.
- Reset asserted mid-operation clears the FIFO contents and any pending strobe immediately, asynchronously.

## Configuration
- NUM_ENTRY_FIFO_BYPASS_EN defined:
  - In IDLE with req=1, empty=1 and a push edge in cycle N, sw_in goes directly to num_out with num_stb high in N+1.
  - The FIFO is not written, count stays 0, and the FSM goes to WAIT_REL.
- Undefined: the same event writes the FIFO and the strobe appears in N+2, as above.

## Structure
- Package num_entry_pkg holds:
  - the state enum (IDLE, WAIT_REL)
  - default DATA_W/DEPTH constants
  - the pointer/count width localparams
- Sub-module entry_fifo: storage array, pointers, count, full/empty, with push/pop inputs and a registered head-read output.
- The top level holds the edge detect, FSM, bypass mux and overflow flag.

## Test plan
- Reset with key_in=1 held, then release: no push, count=0, empty=1, num_stb never pulses.
- req=0; press with sw_in=0x12, then 0x34, then 0x56 → count=3. Raise req → num_stb with 0x12. Lower req, then raise → 0x34. Lower, then raise → 0x56. Lower again → empty.
- DEPTH=4: five presses 0x01..0x05 with req=0 → full=1, overflow=1. Deliveries return 0x01..0x04 only.
- req held high for 10 cycles while 2 entries are queued → exactly one num_stb. Second value is delivered only after req goes low and high again.
- Full FIFO, req high in IDLE, press 0xAA in the pop cycle → count stays 4, overflow stays 0, and 0xAA is the last value delivered.
- Empty FIFO, req=1, press 0x7E: num_stb at N+2 with macro undefined; at N+1 with NUM_ENTRY_FIFO_BYPASS_EN, count staying 0.

Source files
------------

// File: rtl/num_entry_pkg.sv
// rtl/num_entry_pkg.sv - shared types and sizing for the number-entry type-ahead FIFO
package num_entry_pkg;

  // Default geometry: 8-bit switch field, four type-ahead entries
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // Pointer and occupancy widths for the default geometry
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF = PTR_W_DEF + 1;

  // Delivery handshake states
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } state_e;

  // Occupancy counter width for a given depth (needs one extra bit to hold DEPTH)
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/entry_fifo.sv
// rtl/entry_fifo.sv - storage, pointers and occupancy for the type-ahead FIFO
module entry_fifo
  import num_entry_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      empty_o,
  output logic                      full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rdata_q;
  logic              push_ok;
  logic              pop_ok;

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle
  assign push_ok = push_i && (!full_o || pop_ok);
  assign pop_ok  = pop_i && !empty_o;

  // Storage, power-of-two pointer wrap, occupancy and registered head read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rdata_q  <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = rdata_q;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/num_entry_fifo.sv
// rtl/num_entry_fifo.sv - key-press capture and one-shot delivery to the CPU number input (option: NUM_ENTRY_FIFO_BYPASS_EN)
module num_entry_fifo
  import num_entry_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_in,
  input  logic [DATA_W-1:0]         sw_in,
  input  logic                      req,
  output logic [DATA_W-1:0]         num_out,
  output logic                      num_stb,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow
);

  state_e            state_q;
  logic              key_q;
  logic              num_stb_q;
  logic              overflow_q;
  logic              push_req;
  logic              pop_go;
  logic              byp_go;
  logic              fifo_push;
  logic [DATA_W-1:0] fifo_rdata;

  assign push_req = key_in && !key_q;
  assign pop_go   = (state_q == IDLE) && req && !empty;

`ifdef NUM_ENTRY_FIFO_BYPASS_EN
  // An empty FIFO with the CPU already waiting hands the press straight through
  assign byp_go = (state_q == IDLE) && req && empty && push_req;
`else
  assign byp_go = 1'b0;
`endif

  assign fifo_push = push_req && !byp_go;

  entry_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (pop_go),
    .wdata_i (sw_in),
    .rdata_o (fifo_rdata),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  // Key edge detect; reset high so a key held through reset is not a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= 1'b1;
    end else begin
      key_q <= key_in;
    end
  end

  // Sticky overflow: a press lost because the FIFO was full with no pop to make room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (fifo_push && full && !pop_go) begin
      overflow_q <= 1'b1;
    end
  end

  // Delivery FSM: one strobe per request, then wait for the CPU to drop req
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      num_stb_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_go || byp_go) begin
            num_stb_q <= 1'b1;
            state_q   <= WAIT_REL;
          end else begin
            num_stb_q <= 1'b0;
          end
        end
        WAIT_REL: begin
          num_stb_q <= 1'b0;
          if (!req) begin
            state_q <= IDLE;
          end
        end
        default: begin
          num_stb_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

`ifdef NUM_ENTRY_FIFO_BYPASS_EN
  logic [DATA_W-1:0] byp_data_q;
  logic              byp_sel_q;

  // Remember which source fed the last delivery so num_out holds it afterwards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_data_q <= '0;
      byp_sel_q  <= 1'b0;
    end else if (byp_go) begin
      byp_data_q <= sw_in;
      byp_sel_q  <= 1'b1;
    end else if (pop_go) begin
      byp_sel_q  <= 1'b0;
    end
  end

  assign num_out = byp_sel_q ? byp_data_q : fifo_rdata;
`else
  assign num_out = fifo_rdata;
`endif

  assign num_stb  = num_stb_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_num_entry_fifo.sv
// tb/tb_num_entry_fifo.sv - queue-model bench for num_entry_fifo
module tb_num_entry_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              key_in;
  logic [DATA_W-1:0] sw_in;
  logic              req;
  logic [DATA_W-1:0] num_out;
  logic              num_stb;
  logic [2:0]        count;
  logic              empty;
  logic              full;
  logic              overflow;

  num_entry_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .sw_in    (sw_in),
    .req      (req),
    .num_out  (num_out),
    .num_stb  (num_stb),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: a queue of pending values and a "delivered, awaiting release" flag
  bit              m_prev_key;
  byte unsigned    m_q[$];
  bit              m_wait;
  bit              m_stb;
  bit              m_ovf;
  logic [7:0]      m_out;
  byte unsigned    got[$];

  always @(posedge clk) begin
    bit press;
    bit deliver;
    if (rst) begin
      m_prev_key = 1'b1;
      m_q.delete();
      m_wait = 1'b0;
      m_stb  = 1'b0;
      m_ovf  = 1'b0;
      m_out  = 8'h00;
    end else begin
      press      = key_in && !m_prev_key;
      m_prev_key = key_in;
      deliver    = 1'b0;
      if (!m_wait && req && m_q.size() > 0) begin
        m_out   = m_q.pop_front();
        deliver = 1'b1;
      end
`ifdef NUM_ENTRY_FIFO_BYPASS_EN
      else if (!m_wait && req && press) begin
        m_out   = sw_in;
        deliver = 1'b1;
        press   = 1'b0;
      end
`endif
      if (press) begin
        if (m_q.size() < DEPTH) m_q.push_back(sw_in);
        else m_ovf = 1'b1;
      end
      m_wait = deliver ? 1'b1 : (m_wait && req);
      m_stb  = deliver;
    end
    #1;
    check("num_stb",  num_stb,  m_stb);
    check("num_out",  num_out,  m_out);
    check("count",    count,    m_q.size());
    check("empty",    empty,    m_q.size() == 0);
    check("full",     full,     m_q.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    if (num_stb) got.push_back(num_out);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; key_in = 1'b0; req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got.delete();
  endtask

  task automatic press(input logic [7:0] v);
    sw_in = v; key_in = 1'b1;
    @(negedge clk);
    key_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic deliver_one(input string name);
    int k;
    req = 1'b1;
    k = 0;
    while (!num_stb && k < 10) begin
      @(negedge clk);
      k++;
    end
    check({name, "_seen"}, num_stb, 1);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b1; key_in = 1'b1; req = 1'b0; sw_in = 8'h00;

    // Key held through reset release must not push
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_no_stb", got.size(), 0);
    key_in = 1'b0;
    @(negedge clk);

    // Three presses then three separate requests, in order
    do_reset();
    press(8'h12); press(8'h34); press(8'h56);
    check("t2_count3", count, 3);
    deliver_one("t2_d0"); deliver_one("t2_d1"); deliver_one("t2_d2");
    check("t2_ndeliv", got.size(), 3);
    check("t2_v0", got[0], 8'h12);
    check("t2_v1", got[1], 8'h34);
    check("t2_v2", got[2], 8'h56);
    check("t2_empty", empty, 1);

    // Five presses into four entries: fifth lost, overflow sticky
    do_reset();
    for (int i = 1; i <= 5; i++) press(8'(i));
    check("t3_full", full, 1);
    check("t3_ovf", overflow, 1);
    check("t3_count", count, 4);
    for (int i = 0; i < 4; i++) deliver_one("t3_d");
    req = 1'b1;
    repeat (5) @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("t3_ndeliv", got.size(), 4);
    check("t3_v0", got[0], 8'h01);
    check("t3_v3", got[3], 8'h04);
    check("t3_ovf_sticky", overflow, 1);

    // req held high: exactly one strobe until it is released
    do_reset();
    press(8'h21); press(8'h22);
    req = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_one_stb", got.size(), 1);
    check("t4_count", count, 1);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    repeat (3) @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("t4_two_stb", got.size(), 2);
    check("t4_v1", got[1], 8'h22);

    // Press during the pop cycle of a full FIFO: accepted, no overflow
    do_reset();
    press(8'hA1); press(8'hA2); press(8'hA3); press(8'hA4);
    sw_in = 8'hAA; key_in = 1'b1; req = 1'b1;
    @(negedge clk);
    key_in = 1'b0; req = 1'b0;
    check("t5_count", count, 4);
    check("t5_ovf", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) deliver_one("t5_d");
    check("t5_ndeliv", got.size(), 5);
    check("t5_v0", got[0], 8'hA1);
    check("t5_last", got[4], 8'hAA);

    // Empty FIFO with CPU waiting: latency from press to strobe
    do_reset();
    req = 1'b1; sw_in = 8'h7E; key_in = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      key_in = 1'b0;
    end while (!num_stb && k < 10);
`ifdef NUM_ENTRY_FIFO_BYPASS_EN
    check("t6_latency", k, 1);
`else
    check("t6_latency", k, 2);
`endif
    check("t6_value", num_out, 8'h7E);
    check("t6_count", count, 0);
    req = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
